// File: rtl/demultiplexer_dispatch_if.sv
// rtl/demultiplexer_dispatch_if.sv - task stream and four-lane output bundle for the dispatcher
interface demultiplexer_dispatch_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic [1:0]          in_sel;
  logic [1:0]          grant_lane;
  logic [3:0]          out_valid;
  logic [3:0]          out_ready;
  logic [4*DATA_W-1:0] out_data;
  logic [4*CW-1:0]     lane_count;
  logic                busy;

  // Task source side plus lane consumers.
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, grant_lane, out_valid, out_data, lane_count, busy
  );

  // Dispatcher side.
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, grant_lane, out_valid, out_data, lane_count, busy
  );
endinterface

// File: rtl/demultiplexer_dispatch.sv
// rtl/demultiplexer_dispatch.sv - 1:4 task dispatcher with per-lane FIFOs; DISPATCH_AUTO_SEL_EN enables round-robin lane choice
module demultiplexer_dispatch #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input logic                     clk,
  input logic                     rst,
  demultiplexer_dispatch_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [4][DEPTH];
  logic [AW-1:0]     wr_q [4];
  logic [AW-1:0]     wr_d [4];
  logic [AW-1:0]     rd_q [4];
  logic [AW-1:0]     rd_d [4];
  logic [CW-1:0]     cnt_q [4];
  logic [CW-1:0]     cnt_d [4];
  logic [DATA_W-1:0] head_q [4];
  logic [DATA_W-1:0] head_d [4];

  logic [3:0] full;
  logic [3:0] valid;
  logic [3:0] push;
  logic [3:0] pop;
  logic [1:0] grant;
  logic       ready;
  logic       accept;

  // Per-lane status decoded from the occupancy registers.
  always_comb begin
    full  = '0;
    valid = '0;
    for (int i = 0; i < 4; i++) begin
      full[i]  = (cnt_q[i] == CW'(DEPTH));
      valid[i] = (cnt_q[i] != '0);
    end
  end

`ifdef DISPATCH_AUTO_SEL_EN
  logic [1:0] rr_q;
  logic [1:0] rr_d;

  // Pick the first non-full lane starting at the round-robin pointer.
  always_comb begin
    logic [1:0] idx;
    grant = rr_q;
    ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_q + k[1:0];
      if (!ready && !full[idx]) begin
        grant = idx;
        ready = 1'b1;
      end
    end
    rr_d = (bus.in_valid && ready) ? grant + 2'd1 : rr_q;
  end

  // Round-robin pointer moves past the lane that just took a word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  // Route strictly by the requested lane; readiness never looks at out_ready.
  always_comb begin
    grant = bus.in_sel;
    ready = !full[bus.in_sel];
  end
`endif

  // Handshake decode: one push lane per accept, any set of lanes may pop.
  always_comb begin
    accept = bus.in_valid & ready;
    push   = '0;
    pop    = '0;
    for (int i = 0; i < 4; i++) begin
      push[i] = accept && (grant == 2'(i));
      pop[i]  = valid[i] & bus.out_ready[i];
    end
  end

  // Lane next state; the head register mirrors FIFO[rdptr] and holds when the lane drains.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      wr_d[i]   = wr_q[i] + AW'(push[i]);
      rd_d[i]   = rd_q[i] + AW'(pop[i]);
      cnt_d[i]  = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      head_d[i] = head_q[i];
      if (cnt_d[i] != '0) begin
        // A push lands on the new head slot only when the lane ends up holding just that word.
        head_d[i] = (push[i] && (wr_q[i] == rd_d[i])) ? bus.in_data : mem_q[i][rd_d[i]];
      end
    end
  end

  // Pointer, occupancy and head registers; reset drops everything stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        wr_q[i]   <= '0;
        rd_q[i]   <= '0;
        cnt_q[i]  <= '0;
        head_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        wr_q[i]   <= wr_d[i];
        rd_q[i]   <= rd_d[i];
        cnt_q[i]  <= cnt_d[i];
        head_q[i] <= head_d[i];
      end
    end
  end

  // FIFO storage is only ever read behind a valid count, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        mem_q[i][wr_q[i]] <= bus.in_data;
      end
    end
  end

  // Flatten lane state onto the bus.
  always_comb begin
    bus.out_data   = '0;
    bus.lane_count = '0;
    for (int i = 0; i < 4; i++) begin
      bus.out_data[i*DATA_W +: DATA_W] = head_q[i];
      bus.lane_count[i*CW +: CW]       = cnt_q[i];
    end
    bus.out_valid  = valid;
    bus.busy       = |valid;
    bus.in_ready   = ready;
    bus.grant_lane = grant;
  end
endmodule

// File: tb/tb_demultiplexer_dispatch.sv
// tb/tb_demultiplexer_dispatch.sv - directed self-checking bench for demultiplexer_dispatch
module tb_demultiplexer_dispatch;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  demultiplexer_dispatch_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  demultiplexer_dispatch #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] sel, input logic [7:0] data);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_data  = data;
    step();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'd0;
    bus.in_data   = 8'h00;
    bus.out_ready = 4'b0000;
    step();
    step();
    rst = 1'b0;

`ifdef DISPATCH_AUTO_SEL_EN
    check("auto_reset_grant", 32'(bus.grant_lane), 32'd0);
    check("auto_reset_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.in_data = 8'h80 + 8'(k);
      check($sformatf("auto_grant_%0d", k), 32'(bus.grant_lane), 32'(k % 4));
      check($sformatf("auto_ready_%0d", k), 32'(bus.in_ready), 32'd1);
      step();
    end
    check("auto_all_full_count", 32'(bus.lane_count), 32'hAA);
    check("auto_9th_ready", 32'(bus.in_ready), 32'd0);
    check("auto_9th_grant", 32'(bus.grant_lane), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0100;
    check("auto_pop_cycle_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.out_ready = 4'b0000;
    check("auto_after_pop_grant", 32'(bus.grant_lane), 32'd2);
    check("auto_after_pop_ready", 32'(bus.in_ready), 32'd1);
    check("auto_lane2_head", 32'(bus.out_data[23:16]), 32'h86);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h90;
    step();
    bus.in_valid = 1'b0;
    check("auto_refill_count", 32'(bus.lane_count), 32'hAA);
    check("auto_refull_ready", 32'(bus.in_ready), 32'd0);
    check("auto_refull_grant", 32'(bus.grant_lane), 32'd3);
`else
    // Load lanes to 2,2,1,0 then reset asynchronously.
    push(2'd0, 8'h10);
    push(2'd0, 8'h11);
    push(2'd1, 8'h20);
    push(2'd1, 8'h21);
    push(2'd2, 8'h30);
    check("load_count", 32'(bus.lane_count), 32'h1A);
    check("load_valid", 32'(bus.out_valid), 32'b0111);
    bus.in_sel = 2'd0;
    #2 rst = 1'b1;
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_count", 32'(bus.lane_count), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_data", bus.out_data, 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_grant", 32'(bus.grant_lane), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_count", 32'(bus.lane_count), 32'd0);

    // Single push to lane 2, visible next cycle.
    bus.in_valid = 1'b1;
    bus.in_sel   = 2'd2;
    bus.in_data  = 8'hA5;
    check("sel2_grant", 32'(bus.grant_lane), 32'd2);
    check("sel2_ready", 32'(bus.in_ready), 32'd1);
    check("sel2_no_bypass", 32'(bus.out_valid), 32'd0);
    step();
    bus.in_valid = 1'b0;
    check("sel2_valid", 32'(bus.out_valid), 32'b0100);
    check("sel2_data", 32'(bus.out_data[23:16]), 32'hA5);
    check("sel2_count", 32'(bus.lane_count), 32'h10);
    check("sel2_busy", 32'(bus.busy), 32'd1);
    bus.out_ready = 4'b0100;
    step();
    bus.out_ready = 4'b0000;
    check("sel2_drained", 32'(bus.out_valid), 32'd0);
    check("sel2_hold_data", 32'(bus.out_data[23:16]), 32'hA5);

    // Lane 1 fills while its consumer stalls; other lanes stay open.
    push(2'd1, 8'h11);
    push(2'd1, 8'h22);
    check("lane1_full_count", 32'(bus.lane_count), 32'h08);
    bus.in_sel = 2'd1;
    #1;
    check("lane1_full_ready", 32'(bus.in_ready), 32'd0);
    bus.in_sel = 2'd0;
    #1;
    check("lane0_open_ready", 32'(bus.in_ready), 32'd1);
    check("lane1_head_first", 32'(bus.out_data[15:8]), 32'h11);
    bus.in_valid  = 1'b1;
    bus.in_sel    = 2'd1;
    bus.in_data   = 8'h99;
    bus.out_ready = 4'b0010;
    #1;
    check("lane1_full_pop_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.in_valid = 1'b0;
    check("lane1_pop1_count", 32'(bus.lane_count), 32'h04);
    check("lane1_pop1_head", 32'(bus.out_data[15:8]), 32'h22);
    step();
    bus.out_ready = 4'b0000;
    check("lane1_pop2_count", 32'(bus.lane_count), 32'h00);
    check("lane1_pop2_valid", 32'(bus.out_valid), 32'd0);

    // Lane 3 steady at one entry with push+pop every cycle, wrapping pointers.
    push(2'd3, 8'h30);
    check("lane3_one_count", 32'(bus.lane_count), 32'h40);
    bus.out_ready = 4'b1000;
    bus.in_sel    = 2'd3;
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'h33 + 8'(k);
      step();
      check($sformatf("lane3_pp_count_%0d", k), 32'(bus.lane_count), 32'h40);
      check($sformatf("lane3_pp_head_%0d", k), 32'(bus.out_data[31:24]), 32'(8'h33 + 8'(k)));
    end
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 4'b0000;
    check("lane3_drained", 32'(bus.out_valid), 32'd0);

    // All lanes pop together.
    push(2'd0, 8'h01);
    push(2'd1, 8'h02);
    push(2'd2, 8'h03);
    push(2'd3, 8'h04);
    check("all_valid", 32'(bus.out_valid), 32'b1111);
    check("all_count", 32'(bus.lane_count), 32'h55);
    check("all_data", bus.out_data, 32'h04030201);
    bus.out_ready = 4'b1111;
    step();
    bus.out_ready = 4'b0000;
    check("all_pop_valid", 32'(bus.out_valid), 32'd0);
    check("all_pop_busy", 32'(bus.busy), 32'd0);
    check("all_pop_count", 32'(bus.lane_count), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/demultiplexer_dispatch.md
Name: demultiplexer_dispatch

Overview:
- Inverse of the scheduler's 4:1 select path: accepts one task stream and routes each task to one of four lanes, selected by a 2-bit lane select.
- Each lane has a small FIFO with its own valid/ready handshake, so a stalled consumer never blocks the other lanes.
- Sits between the scheduler's task issue point and four processing-element ports.

Parameters:
- DATA_W, 8, width of one task word.
- DEPTH, 2, entries per lane FIFO. Must be a power of 2, ≥2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  task word present on in_data.
- in_ready  output  1  dispatcher can accept the task word this cycle.
- in_data  input  DATA_W  task word.
- in_sel  input  2  destination lane: 00→lane0, 01→lane1, 10→lane2, 11→lane3.
- grant_lane  output  2  lane that an accept this cycle writes to (combinational).
- out_valid  output  4  bit i: lane i head entry is valid.
- out_ready  input  4  bit i: lane i consumer takes the head entry.
- out_data  output  4*DATA_W  lane i head word on bits [i*DATA_W +: DATA_W].
- lane_count  output  4*CW  lane i occupancy, where CW = clog2(DEPTH+1).
- busy  output  1  OR of all out_valid bits.

Behaviour:
- Reset (asynchronous assert; removal synchronous to clk):
  - All FIFOs empty; read/write pointers = 0.
  - out_valid = 0, out_data = 0, lane_count = 0, busy = 0.
  - Round-robin pointer = 0.
  - in_ready and grant_lane follow from the reset state.
- Reset mid-operation discards all stored words. No partial handshake survives reset.
- Selection (macro undefined):
  - grant_lane = in_sel.
  - in_ready = !full[in_sel].
  - in_ready depends only on in_sel and registered state, never on out_ready.
- Accept = in_valid & in_ready. It writes in_data to lane grant_lane at its write pointer and advances that pointer.
- Pop on lane i = out_valid[i] & out_ready[i]. It advances that lane's read pointer.
- Pointers wrap modulo DEPTH. Occupancy is tracked by a count register per lane (0..DEPTH).
- Latency: a word accepted at edge N is visible on out_valid/out_data after edge N (next cycle). There is no same-cycle bypass.
- out_data[i] = FIFO[i][rdptr]. It holds stable while out_valid[i] & !out_ready[i].
- When a lane is empty, its out_data holds the last value. Only out_valid qualifies it.
- Simultaneous push and pop on the same non-full lane: count unchanged, both pointers advance.
- Full lane with a pop this cycle: in_ready is still 0 for that lane. The push is refused and retried next cycle.
- Pop on an empty lane is impossible, because out_valid = 0.
- Any number of lanes may pop in the same cycle; lanes are independent.
- in_valid with in_ready = 0: no state change. The source must hold in_data/in_sel stable until accepted.
- lane_count is registered and equals the count register.
- busy = |out_valid.

Optional Feature:
- Macro: DISPATCH_AUTO_SEL_EN.
- Defined:
  - in_sel is ignored.
  - Round-robin pointer rr (2 bits). grant_lane = first non-full lane scanning rr, rr+1, rr+2, rr+3 (mod 4).
  - in_ready = any lane non-full.
  - On accept, rr ← grant_lane+1 (mod 4). rr is unchanged when there is no accept.
  - If all lanes are full, grant_lane = rr and in_ready = 0.
- Undefined: routing strictly by in_sel as above. The rr register is not built.

Test Plan:
- Reset with all lanes loaded (lane_count = 2,2,1,0) → next cycle: out_valid = 0000, lane_count = 0, busy = 0, out_data = 0.
- in_sel = 2, in_data = 0xA5, accept at edge N → out_valid = 0100 and lane2 data = 0xA5 from edge N; other lanes unchanged; lane2 count = 1.
- Lane1 out_ready = 0; push 0x11, 0x22 → lane1 count = 2, in_ready = 0 for in_sel = 1 while in_ready = 1 for in_sel = 0; then out_ready[1] = 1 → 0x11 then 0x22 popped in order; count returns to 0.
- Lane3 count = 1, simultaneous push 0x33 and pop → count stays 1, head becomes 0x33; pointer wrap verified over 10 push/pop pairs.
- All four lanes pop in one cycle with counts 1,1,1,1 → all out_valid = 0 next cycle, busy = 0.
- DISPATCH_AUTO_SEL_EN defined, out_ready = 0000, 9 pushes → grants 0,1,2,3,0,1,2,3 then in_ready = 0 on the 9th; pop lane2 → next grant = 2.
